// File: rtl/spi_master_shifter_if.sv
// Bus bundle for spi_master_shifter: register-block handshake plus the
// divider and serial pins. The "master" view is taken by the shift engine;
// the "slave" view is taken by whatever drives it (register block, divider,
// SPI slave, or a testbench).
interface spi_master_shifter_if #(
   parameter int unsigned DATA_WIDTH = 8
);
   logic                  start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  sck_in;
   logic                  miso;
   logic                  en_div;
   logic                  cs_n;
   logic                  mosi;
   logic                  busy;
   logic                  done;
   logic [DATA_WIDTH-1:0] rx_data;

   modport master (
      input  start, tx_data, sck_in, miso,
      output en_div, cs_n, mosi, busy, done, rx_data
   );

   modport slave (
      output start, tx_data, sck_in, miso,
      input  en_div, cs_n, mosi, busy, done, rx_data
   );
endinterface

// File: rtl/spi_master_shifter.sv
// SPI mode-0 (CPOL=0, CPHA=0) master shift engine, MSB first.
// Gates an external SCK divider through en_div and edge-detects its SCK in the
// clk_cpu domain. Frames each word with CS_n setup/hold time, shifts tx_data out
// on MOSI, samples MISO on SCK rise, and reports via a start/busy/done handshake.
module spi_master_shifter #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned CS_SETUP   = 2,
   parameter int unsigned CS_HOLD    = 2
) (
   input  logic                 clk_cpu,
   input  logic                 rst,
   spi_master_shifter_if.master bus
);

   localparam int unsigned BW      = $clog2(DATA_WIDTH + 1);
   localparam int unsigned CNT_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int unsigned CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   // Only the bits still to be sent after the one currently on MOSI are kept;
   // the top of this register is always the next MOSI bit.
   logic [DATA_WIDTH-2:0] tx_sr_q, tx_sr_d;
   logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  en_div_q, en_div_d;
   logic                  cs_n_q, cs_n_d;
   logic                  mosi_q, mosi_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  sck_q;
   logic                  rise;
   logic                  fall;

   assign rise = bus.sck_in & ~sck_q;
   assign fall = ~bus.sck_in & sck_q;

   assign bus.en_div  = en_div_q;
   assign bus.cs_n    = cs_n_q;
   assign bus.mosi    = mosi_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.rx_data = rx_data_q;

   // SCK history for edge detection in the clk_cpu domain.
   always_ff @(posedge clk_cpu or posedge rst) begin
      if (rst) begin
         sck_q <= 1'b0;
      end else begin
         sck_q <= bus.sck_in;
      end
   end

   // State and datapath registers; reset forces CS_n high and the divider off at once.
   always_ff @(posedge clk_cpu or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_cnt_q <= '0;
         tx_sr_q   <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         en_div_q  <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_cnt_q <= bit_cnt_d;
         tx_sr_q   <= tx_sr_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         en_div_q  <= en_div_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and next-datapath logic for the transfer sequence.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_cnt_d = bit_cnt_q;
      tx_sr_d   = tx_sr_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      en_div_d  = en_div_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               tx_sr_d = bus.tx_data[DATA_WIDTH-2:0];
               mosi_d  = bus.tx_data[DATA_WIDTH-1];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               state_d = SETUP;
            end
         end

         SETUP: begin
            if (cnt_q == CW'(CS_SETUP - 1)) begin
               en_div_d  = 1'b1;
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         SHIFT: begin
            if (rise) begin
               rx_sr_d = {rx_sr_q[DATA_WIDTH-2:0], bus.miso};
               if (bit_cnt_q != BW'(DATA_WIDTH)) begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end else if (fall) begin
               if (bit_cnt_q != BW'(DATA_WIDTH)) begin
                  mosi_d  = tx_sr_q[DATA_WIDTH-2];
                  tx_sr_d = tx_sr_q << 1;
               end else begin
                  en_div_d = 1'b0;
                  mosi_d   = 1'b0;
                  cnt_d    = '0;
                  state_d  = HOLD;
               end
            end
         end

         HOLD: begin
            if (cnt_q == CW'(CS_HOLD - 1)) begin
               cs_n_d    = 1'b1;
               rx_data_d = rx_sr_q;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Directed bench for spi_master_shifter: behavioural SCK divider, mode-0
// shift-register slave (or MOSI->MISO loopback), and a bus monitor that
// records MOSI bits at each SCK rise and the CS_n framing times.
module tb_spi_master_shifter;

   logic clk_cpu = 1'b0;
   logic rst     = 1'b1;

   always #5 clk_cpu = ~clk_cpu;

   spi_master_shifter_if #(.DATA_WIDTH(8)) bus ();

   spi_master_shifter #(
      .DATA_WIDTH(8),
      .CS_SETUP  (2),
      .CS_HOLD   (2)
   ) dut (
      .clk_cpu(clk_cpu),
      .rst    (rst),
      .bus    (bus)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   // Divider model: SCK toggles every 'half' enabled cycles, held low while disabled.
   int unsigned half     = 3;
   int unsigned div_cnt  = 0;
   logic        div_sck  = 1'b0;
   logic        tog_mode = 1'b0;
   logic        tog_sck  = 1'b0;

   always @(posedge clk_cpu or posedge rst) begin
      if (rst) begin
         div_sck <= 1'b0;
         div_cnt <= 0;
      end else if (!bus.en_div) begin
         div_sck <= 1'b0;
         div_cnt <= 0;
      end else if (div_cnt == half - 1) begin
         div_sck <= ~div_sck;
         div_cnt <= 0;
      end else begin
         div_cnt <= div_cnt + 1;
      end
   end

   assign bus.sck_in = tog_mode ? tog_sck : div_sck;

   // Slave, monitor and framing timestamps.
   logic        loopback   = 1'b1;
   logic [7:0]  slave_word = 8'h00;
   logic [7:0]  slave_sr   = 8'h00;
   logic [7:0]  mosi_sr    = 8'h00;
   logic        m_sck_p    = 1'b0;
   logic        m_cs_p     = 1'b1;
   int unsigned cyc           = 0;
   int unsigned rise_cnt      = 0;
   int unsigned frame_rises   = 0;
   int unsigned done_cnt      = 0;
   int unsigned cs_fall_cyc   = 0;
   int unsigned first_rise_cyc = 0;
   int unsigned last_fall_cyc = 0;
   int unsigned cs_rise_cyc   = 0;

   assign bus.miso = loopback ? bus.mosi : slave_sr[7];

   always @(posedge clk_cpu) begin
      cyc     <= cyc + 1;
      m_sck_p <= bus.sck_in;
      m_cs_p  <= bus.cs_n;
      if (m_cs_p && !bus.cs_n) begin
         cs_fall_cyc <= cyc;
         frame_rises <= 0;
         slave_sr    <= slave_word;
      end else if (!bus.cs_n && m_sck_p && !bus.sck_in) begin
         last_fall_cyc <= cyc;
         slave_sr      <= slave_sr << 1;
      end
      if (!bus.cs_n && bus.sck_in && !m_sck_p) begin
         rise_cnt <= rise_cnt + 1;
         mosi_sr  <= {mosi_sr[6:0], bus.mosi};
         if (frame_rises == 0) first_rise_cyc <= cyc;
         frame_rises <= frame_rises + 1;
      end
      if (!m_cs_p && bus.cs_n) cs_rise_cyc <= cyc;
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
   endtask

   task automatic chk_ge(input string nm, input int unsigned act, input int unsigned lim);
      n_total++;
      if (act >= lim) n_pass++;
      else $display("FAIL %s: got %0d, want >= %0d", nm, act, lim);
   endtask

   task automatic step;
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic start_xfer(input logic [7:0] tx, input logic [7:0] sw, input logic lp,
                             input int unsigned hr);
      slave_word  = sw;
      loopback    = lp;
      half        = hr;
      bus.tx_data = tx;
      bus.start   = 1'b1;
      step();
      bus.start   = 1'b0;
   endtask

   task automatic wait_done(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (bus.done) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic wait_rises(input int unsigned target, output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (rise_cnt >= target) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   typedef struct {
      string       name;
      logic [7:0]  tx;
      logic [7:0]  sw;
      logic        lp;
      int unsigned hr;
      logic [7:0]  exp_rx;
   } vec_t;

   vec_t vecs[4];

   initial begin
      logic        ok;
      int unsigned d0;
      int unsigned r0;
      logic [7:0]  rx1;

      vecs[0] = '{"loop_a5",  8'hA5, 8'h00, 1'b1, 3, 8'hA5};
      vecs[1] = '{"slave_3c", 8'h00, 8'h3C, 1'b0, 3, 8'h3C};
      vecs[2] = '{"slave_96", 8'hC3, 8'h96, 1'b0, 6, 8'h96};
      vecs[3] = '{"loop_ff",  8'hFF, 8'h00, 1'b1, 2, 8'hFF};

      // Reset with start held and SCK toggling.
      bus.start   = 1'b1;
      bus.tx_data = 8'hA5;
      tog_mode    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #3 tog_sck = ~tog_sck;
      end
      step();
      step();
      chk("rst_cs_n",   {31'd0, bus.cs_n},   32'd1);
      chk("rst_en_div", {31'd0, bus.en_div}, 32'd0);
      chk("rst_busy",   {31'd0, bus.busy},   32'd0);
      chk("rst_done",   {31'd0, bus.done},   32'd0);
      chk("rst_mosi",   {31'd0, bus.mosi},   32'd0);
      chk("rst_rx",     {24'd0, bus.rx_data}, 32'd0);
      bus.start = 1'b0;
      tog_mode  = 1'b0;
      tog_sck   = 1'b0;
      rst       = 1'b0;
      repeat (3) step();
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
      chk("idle_cs_n", {31'd0, bus.cs_n}, 32'd1);

      // Table-driven single transfers.
      foreach (vecs[k]) begin
         d0 = done_cnt;
         start_xfer(vecs[k].tx, vecs[k].sw, vecs[k].lp, vecs[k].hr);
         chk({vecs[k].name, "_busy"}, {31'd0, bus.busy}, 32'd1);
         wait_done(ok);
         chk({vecs[k].name, "_done_seen"}, {31'd0, ok}, 32'd1);
         chk({vecs[k].name, "_rx"}, {24'd0, bus.rx_data}, {24'd0, vecs[k].exp_rx});
         step();
         chk({vecs[k].name, "_done_1cyc"}, {31'd0, bus.done}, 32'd0);
         chk({vecs[k].name, "_busy_low"}, {31'd0, bus.busy}, 32'd0);
         chk({vecs[k].name, "_mosi_bits"}, {24'd0, mosi_sr}, {24'd0, vecs[k].tx});
         chk({vecs[k].name, "_rises"}, frame_rises, 32'd8);
         chk({vecs[k].name, "_done_cnt"}, done_cnt - d0, 32'd1);
         chk_ge({vecs[k].name, "_cs_setup"}, first_rise_cyc - cs_fall_cyc, 2);
         chk_ge({vecs[k].name, "_cs_hold"}, cs_rise_cyc - last_fall_cyc, 2);
         repeat (2) step();
      end

      // Start pulsed again mid-transfer with different data: must be ignored.
      d0 = done_cnt;
      r0 = rise_cnt;
      start_xfer(8'h66, 8'hB4, 1'b0, 3);
      wait_rises(r0 + 3, ok);
      chk("busy_start_rises", {31'd0, ok}, 32'd1);
      bus.tx_data = 8'hFF;
      bus.start   = 1'b1;
      step();
      bus.start   = 1'b0;
      wait_done(ok);
      chk("busy_start_done", {31'd0, ok}, 32'd1);
      chk("busy_start_rx", {24'd0, bus.rx_data}, 32'h0000_00B4);
      step();
      chk("busy_start_mosi", {24'd0, mosi_sr}, 32'h0000_0066);
      repeat (30) step();
      chk("busy_start_one_done", done_cnt - d0, 32'd1);
      chk("busy_start_idle", {31'd0, bus.busy}, 32'd0);

      // Asynchronous reset after the 4th rise, then a clean transfer.
      d0 = done_cnt;
      r0 = rise_cnt;
      start_xfer(8'h5A, 8'h00, 1'b1, 3);
      wait_rises(r0 + 4, ok);
      chk("mid_rst_rises", {31'd0, ok}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_cs_n",   {31'd0, bus.cs_n},   32'd1);
      chk("mid_rst_en_div", {31'd0, bus.en_div}, 32'd0);
      chk("mid_rst_busy",   {31'd0, bus.busy},   32'd0);
      step();
      step();
      rst = 1'b0;
      repeat (10) step();
      chk("mid_rst_no_done", done_cnt - d0, 32'd0);
      chk("mid_rst_rx", {24'd0, bus.rx_data}, 32'd0);
      start_xfer(8'h81, 8'h00, 1'b1, 3);
      wait_done(ok);
      chk("post_rst_done", {31'd0, ok}, 32'd1);
      chk("post_rst_rx", {24'd0, bus.rx_data}, 32'h0000_0081);
      step();
      chk("post_rst_mosi", {24'd0, mosi_sr}, 32'h0000_0081);
      repeat (2) step();

      // Back-to-back: second start the cycle after done, with a slower SCK.
      d0 = done_cnt;
      start_xfer(8'h01, 8'h00, 1'b1, 3);
      wait_done(ok);
      chk("b2b_first_done", {31'd0, ok}, 32'd1);
      rx1 = bus.rx_data;
      start_xfer(8'h80, 8'h00, 1'b1, 6);
      chk("b2b_first_rx", {24'd0, rx1}, 32'h0000_0001);
      chk("b2b_second_busy", {31'd0, bus.busy}, 32'd1);
      wait_done(ok);
      chk("b2b_second_done", {31'd0, ok}, 32'd1);
      chk("b2b_second_rx", {24'd0, bus.rx_data}, 32'h0000_0080);
      step();
      chk("b2b_done_cnt", done_cnt - d0, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
